// File: rtl/wb_commit_unit.sv
// -----------------------------------------------------------------------------
// wb_commit_unit
//   Writeback-side consumer of the MEM/WB pipeline register. It commits GPR
//   writes to a 32-entry register file (r0 hardwired to zero), HI/LO pair
//   writes, and LL/SC link state into the LLbit. It returns write-first
//   bypassed values to ID (GPR reads) and to MEM (HI/LO, LLbit), and keeps a
//   bring-up counter of cycles that committed any write.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   flush                     exception/eret flush, clears LLbit only
//   wb_wd/wb_wreg/wb_wdata    GPR write request from MEM/WB
//   wb_whilo/wb_hi/wb_lo      HI/LO pair write request from MEM/WB
//   wb_LLbit_we/_value        LLbit write request from MEM/WB
//   re1/raddr1/rdata1         GPR read port 1 (combinational, bypassed)
//   re2/raddr2/rdata2         GPR read port 2 (combinational, bypassed)
//   hi_o/lo_o                 current HI/LO (combinational, bypassed)
//   LLbit_o                   current LLbit (combinational, bypassed)
//   commit_cnt                count of cycles with any committed write
// -----------------------------------------------------------------------------
module wb_commit_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              LLbit_o,
  output logic [CNT_W-1:0]  commit_cnt
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] gpr_r [NREG];
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic              llbit_r;
  logic [CNT_W-1:0]  commit_cnt_r;

  logic              gpr_we_s;
  logic              commit_fire_s;

  // Writes to r0 are dropped so that it always reads back as zero.
  assign gpr_we_s      = wb_wreg && (wb_wd != ZERO_ADDR);
  // Several simultaneous writes in one cycle still count as a single commit.
  assign commit_fire_s = gpr_we_s || wb_whilo || wb_LLbit_we;

  // GPR file: cleared on reset, one write port from MEM/WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_r[i] <= ZERO_DATA;
      end
    end else if (gpr_we_s) begin
      gpr_r[wb_wd] <= wb_wdata;
    end else begin
      gpr_r[wb_wd] <= gpr_r[wb_wd];
    end
  end

  // HI/LO pair: always written together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= ZERO_DATA;
      lo_r <= ZERO_DATA;
    end else if (wb_whilo) begin
      hi_r <= wb_hi;
      lo_r <= wb_lo;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // LLbit: a flush breaks the link even if an LL commits in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_r <= 1'b0;
    end else if (flush) begin
      llbit_r <= 1'b0;
    end else if (wb_LLbit_we) begin
      llbit_r <= wb_LLbit_value;
    end else begin
      llbit_r <= llbit_r;
    end
  end

  // Commit counter, free-running wrap at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_r <= ZERO_CNT;
    end else if (commit_fire_s) begin
      commit_cnt_r <= commit_cnt_r + ONE_CNT;
    end else begin
      commit_cnt_r <= commit_cnt_r;
    end
  end

  assign commit_cnt = commit_cnt_r;

  // Read port 1: write-first bypass from the WB write in flight.
  always_comb begin
    rdata1 = ZERO_DATA;
    if (rst) begin
      rdata1 = ZERO_DATA;
    end else if (!re1) begin
      rdata1 = ZERO_DATA;
    end else if (raddr1 == ZERO_ADDR) begin
      rdata1 = ZERO_DATA;
    end else if (wb_wreg && (raddr1 == wb_wd)) begin
      rdata1 = wb_wdata;
    end else begin
      rdata1 = gpr_r[raddr1];
    end
  end

  // Read port 2: identical to port 1, independent address.
  always_comb begin
    rdata2 = ZERO_DATA;
    if (rst) begin
      rdata2 = ZERO_DATA;
    end else if (!re2) begin
      rdata2 = ZERO_DATA;
    end else if (raddr2 == ZERO_ADDR) begin
      rdata2 = ZERO_DATA;
    end else if (wb_wreg && (raddr2 == wb_wd)) begin
      rdata2 = wb_wdata;
    end else begin
      rdata2 = gpr_r[raddr2];
    end
  end

  // HI/LO and LLbit seen by MEM include the write committing this cycle.
  always_comb begin
    hi_o    = ZERO_DATA;
    lo_o    = ZERO_DATA;
    LLbit_o = 1'b0;
    if (rst) begin
      hi_o    = ZERO_DATA;
      lo_o    = ZERO_DATA;
      LLbit_o = 1'b0;
    end else begin
      if (wb_whilo) begin
        hi_o = wb_hi;
        lo_o = wb_lo;
      end else begin
        hi_o = hi_r;
        lo_o = lo_r;
      end
      if (flush) begin
        LLbit_o = 1'b0;
      end else if (wb_LLbit_we) begin
        LLbit_o = wb_LLbit_value;
      end else begin
        LLbit_o = llbit_r;
      end
    end
  end

endmodule
